// File: rtl/hilo_div_ctrl.sv
// Radix-2 restoring divider and sequencer for DIV/DIVU in EX.
// Optional HILO_DIV_FAST_ZERO_EN: zero dividend short-cuts through ZERO.
module hilo_div_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic                  cancel,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall_req,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ZERO,
    S_ON,
    S_END
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvs;
  logic [W-1:0]  r_quotient;
  logic [W-1:0]  r_remainder;
  logic          r_sa;
  logic          r_sb;

  logic          w_sa;
  logic          w_sb;
  logic [W-1:0]  w_mag_a;
  logic [W-1:0]  w_mag_b;
  logic          w_zero;
  logic          w_go;
  logic [W:0]    w_sh;
  logic          w_ge;
  logic [W-1:0]  w_rem_n;
  logic [W-1:0]  w_quo_n;
  logic          w_last;
  logic [W-1:0]  w_q_fix;
  logic [W-1:0]  w_r_fix;

  assign w_sa    = signed_div & dividend[W-1];
  assign w_sb    = signed_div & divisor[W-1];
  assign w_mag_a = w_sa ? (~dividend + 1'b1) : dividend;
  assign w_mag_b = w_sb ? (~divisor + 1'b1) : divisor;
  assign w_go    = start & ~cancel;

`ifdef HILO_DIV_FAST_ZERO_EN
  assign w_zero = (divisor == '0) | (dividend == '0);
`else
  assign w_zero = (divisor == '0);
`endif

  // Partial remainder stays below the divisor, so the
  // low W bits of the difference are exact when w_ge.
  assign w_sh    = {r_rem, r_quo[W-1]};
  assign w_ge    = w_sh >= {1'b0, r_dvs};
  assign w_rem_n = w_ge ? (w_sh[W-1:0] - r_dvs) : w_sh[W-1:0];
  assign w_quo_n = {r_quo[W-2:0], w_ge};
  assign w_last  = r_cnt == CW'(W - 1);

  assign w_q_fix = (r_sa ^ r_sb) ? (~w_quo_n + 1'b1) : w_quo_n;
  assign w_r_fix = r_sa ? (~w_rem_n + 1'b1) : w_rem_n;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) w_next = w_zero ? S_ZERO : S_ON;
      end
      S_ZERO: w_next = cancel ? S_IDLE : S_END;
      S_ON: begin
        if (cancel)      w_next = S_IDLE;
        else if (w_last) w_next = S_END;
      end
      S_END:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_quo <= w_mag_a;
            r_dvs <= w_mag_b;
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        S_ZERO: begin
          if (!cancel) begin
            r_quotient  <= '0;
            r_remainder <= '0;
          end
        end
        S_ON: begin
          if (!cancel) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_quotient  <= w_q_fix;
              r_remainder <= w_r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = (r_state == S_END);
  assign stall_req = ~rst & ~cancel &
                     ((r_state == S_IDLE & start) |
                      (r_state == S_ZERO) |
                      (r_state == S_ON));
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Multi-cycle radix-2 restoring divider and its sequencer, serving DIV/DIVU in the EX stage.
- Accepts a start request from EX and raises a pipeline stall request while iterating.
- Delivers the quotient (LO) and remainder (HI) with a one-cycle done pulse.
- EX forwards these results into the hi/lo write path of the EX/MEM pipeline register.

Parameters:
- DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a division; sampled only in IDLE
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start
- cancel  in  1  abort the current operation (pipeline flush)
- dividend  in  DATA_WIDTH  operand A; sampled with start
- divisor  in  DATA_WIDTH  operand B; sampled with start
- stall_req  out  1  stall the pipeline while the divider is busy
- done  out  1  one-cycle pulse: quotient/remainder valid
- quotient  out  DATA_WIDTH  result for LO
- remainder  out  DATA_WIDTH  result for HI

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; done=0; quotient=0; remainder=0; internal counter, partial remainder and sign flags = 0. stall_req is 0 during reset.
- States: IDLE, ZERO, ON, END.
- IDLE:
  - start=1 and cancel=0: latch signed_div, sign bits and operand magnitudes. Magnitude = two's-complement negate if signed_div and MSB=1; otherwise the raw value.
  - Next state is ZERO if divisor==0; otherwise ON with counter=0.
  - start=1 with cancel=1: ignored.
- ZERO: next state END with quotient=0, remainder=0.
- ON: one restoring step per cycle.
  - Shift {rem,quo} left by 1 and trial-subtract the divisor magnitude.
  - If no borrow, keep the difference and set quo LSB=1.
  - counter increments each cycle; after DATA_WIDTH steps (counter==DATA_WIDTH-1 on the last one), next state is END.
- END:
  - done=1 for exactly this cycle; quotient/remainder are registered with sign fixup on entry to END.
  - Next state is IDLE unconditionally. A start in this cycle is ignored.
- Sign fixup (signed_div=1 only):
  - Quotient is negated iff the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Arithmetic wraps modulo 2^DATA_WIDTH, so 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0.
- quotient/remainder hold their last values until the next END (or reset). They are never cleared by cancel.
- stall_req is combinational:
  - 1 when (IDLE & start & ~cancel), or when state is ZERO or ON, and cancel=0.
  - 0 in END and in IDLE otherwise.
  - So the EX instruction is held from its first cycle until done.
- Latency with a nonzero divisor: start accepted in cycle 0; ON occupies cycles 1..DATA_WIDTH; done=1 in cycle DATA_WIDTH+1 (cycle 33 for width 32).
- Latency with divisor==0: done in cycle 2.
- cancel=1 in ZERO or ON: next state IDLE, no done pulse, stall_req=0 in that same cycle. cancel in END has no effect; done is still pulsed.
- rst asserted mid-operation: returns to the reset state on the next edge, with no done pulse.
- start while not in IDLE is ignored; operands are not re-sampled.

Optional Feature:
- Macro: HILO_DIV_FAST_ZERO_EN.
- Defined: a dividend==0 (with divisor!=0) in IDLE also routes to ZERO. Result: quotient=0, remainder=0, done in cycle 2.
- Not defined: a zero dividend takes the full DATA_WIDTH-iteration path (done in cycle 33, same result values).

Test Plan:
- Reset, then hold start=0 for 5 cycles -> done=0, stall_req=0, quotient=0, remainder=0 throughout.
- DIVU 100/7 -> stall_req=1 in cycles 0..32; done=1 in cycle 33 only; quotient=14, remainder=2.
- DIV -7/2 (0xFFFFFFF9/2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Divisor=0 (dividend=0x1234) -> done in cycle 2, quotient=0, remainder=0. Dividend=0, divisor=5 -> done in cycle 2 with HILO_DIV_FAST_ZERO_EN, in cycle 33 without it.
- Start DIVU 50/5; wait for done; then start 9/4 with cancel=1 at cycle 10 -> stall_req=0 in cycle 10, IDLE in cycle 11, no done, outputs stay 10/0.
- Start DIVU 9/4, assert rst in cycle 5 -> all outputs at reset values after that edge. A new start in the next cycle completes correctly: quotient=2, remainder=1.
